// File: rtl/seg7_pkg.sv
// Shared definitions for the 3-digit multiplexed 7-segment scan driver.
//   slot_e     : digit scan slot encoding (ones -> tens -> hundreds)
//   SEG_*      : active-high segment codes, bit0 = a ... bit6 = g
//   DIG_*      : bit index of each digit within the DIG bus
package seg7_pkg;

  typedef enum logic [1:0] {
    S_ONES  = 2'd0,
    S_TENS  = 2'd1,
    S_HUNDS = 2'd2
  } slot_e;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam int unsigned DIG_ONES  = 0;
  localparam int unsigned DIG_TENS  = 1;
  localparam int unsigned DIG_HUNDS = 2;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i  : 4-bit digit code; 10-15 are shown as a dash
//   code_o : active-high segment pattern, bit0 = a ... bit6 = g
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] code_o
);

  always_comb begin
    code_o = SEG_DASH;
    case (bcd_i)
      4'd0:    code_o = SEG_0;
      4'd1:    code_o = SEG_1;
      4'd2:    code_o = SEG_2;
      4'd3:    code_o = SEG_3;
      4'd4:    code_o = SEG_4;
      4'd5:    code_o = SEG_5;
      4'd6:    code_o = SEG_6;
      4'd7:    code_o = SEG_7;
      4'd8:    code_o = SEG_8;
      4'd9:    code_o = SEG_9;
      default: code_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 3-digit 7-segment display driver.
//   CLK, RESET       : clock, asynchronous active-high reset
//   BCD_1/10/100     : digit inputs, snapshotted once per frame
//   BLANK_LZ         : enable leading-zero blanking of tens/hundreds
//   DISP_EN          : 0 turns every digit off while the scan keeps running
//   SEG              : segments a..g (polarity per ACTIVE_LOW_SEG)
//   DIG              : digit enables ones/tens/hundreds (polarity per ACTIVE_LOW_DIG)
//   FRAME            : one-cycle pulse after each snapshot capture
// All outputs are registered, one cycle behind the internal scan state.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned DEAD           = 4,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_DIG = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] BCD_1,
  input  logic [3:0] BCD_10,
  input  logic [3:0] BCD_100,
  input  logic       BLANK_LZ,
  input  logic       DISP_EN,
  output logic [6:0] SEG,
  output logic [2:0] DIG,
  output logic       FRAME
);

  localparam int unsigned    PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  P_LAST  = PW'(PRESCALE - 1);
  localparam logic [6:0]     SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic [2:0]     DIG_OFF = ACTIVE_LOW_DIG ? 3'b111 : 3'b000;

  logic [PW-1:0] p_q, p_d;
  slot_e         slot_q, slot_d;
  logic [3:0]    snap_1_q, snap_1_d;
  logic [3:0]    snap_10_q, snap_10_d;
  logic [3:0]    snap_100_q, snap_100_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    dig_q, dig_d;
  logic          frame_q, frame_d;

  logic          slot_end;
  logic          capture;
  logic [3:0]    cur_bcd;
  logic [6:0]    cur_code;
  logic          blanked;
  logic          past_dead;
  logic          digit_on;
  logic [2:0]    dig_sel;

  seg7_decode u_decode (
    .bcd_i  (cur_bcd),
    .code_o (cur_code)
  );

  always_comb begin
    slot_end = (p_q == P_LAST);
    p_d      = slot_end ? '0 : p_q + 1'b1;

    slot_d = slot_q;
    if (slot_end) begin
      unique case (slot_q)
        S_ONES:  slot_d = S_TENS;
        S_TENS:  slot_d = S_HUNDS;
        default: slot_d = S_ONES;
      endcase
    end

    // Inputs are captured as the hundreds slot ends so a whole frame shows one value.
    capture    = slot_end && (slot_q == S_HUNDS);
    snap_1_d   = capture ? BCD_1   : snap_1_q;
    snap_10_d  = capture ? BCD_10  : snap_10_q;
    snap_100_d = capture ? BCD_100 : snap_100_q;
    frame_d    = capture;

    cur_bcd = snap_1_q;
    blanked = 1'b0;
    dig_sel = 3'b000;
    unique case (slot_q)
      S_TENS: begin
        cur_bcd = snap_10_q;
        blanked = BLANK_LZ && (snap_100_q == 4'd0) && (snap_10_q == 4'd0);
        dig_sel[DIG_TENS] = 1'b1;
      end
      S_HUNDS: begin
        cur_bcd = snap_100_q;
        blanked = BLANK_LZ && (snap_100_q == 4'd0);
        dig_sel[DIG_HUNDS] = 1'b1;
      end
      default: begin
        cur_bcd = snap_1_q;
        blanked = 1'b0;
        dig_sel[DIG_ONES] = 1'b1;
      end
    endcase

    // Signed compare keeps DEAD == 0 from being a constant unsigned comparison.
    past_dead = (int'(p_q) >= int'(DEAD));
    digit_on  = past_dead && DISP_EN && !blanked;

    seg_d = digit_on ? (cur_code ^ {7{ACTIVE_LOW_SEG}}) : SEG_OFF;
    dig_d = digit_on ? (dig_sel ^ {3{ACTIVE_LOW_DIG}}) : DIG_OFF;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      p_q        <= '0;
      slot_q     <= S_ONES;
      snap_1_q   <= 4'd0;
      snap_10_q  <= 4'd0;
      snap_100_q <= 4'd0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
      frame_q    <= 1'b0;
    end else begin
      p_q        <= p_d;
      slot_q     <= slot_d;
      snap_1_q   <= snap_1_d;
      snap_10_q  <= snap_10_d;
      snap_100_q <= snap_100_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
      frame_q    <= frame_d;
    end
  end

  assign SEG   = seg_q;
  assign DIG   = dig_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count reference model.
module tb_seg7_scan_driver;

  localparam int P         = 8;
  localparam int D         = 2;
  localparam int FRAME_LEN = 3 * P;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] bcd_1, bcd_10, bcd_100;
  logic       blank_lz, disp_en;
  logic [6:0] seg;
  logic [2:0] dig;
  logic       frame;

  seg7_scan_driver #(
    .PRESCALE       (P),
    .DEAD           (D),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_DIG (1'b1)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BCD_1    (bcd_1),
    .BCD_10   (bcd_10),
    .BCD_100  (bcd_100),
    .BLANK_LZ (blank_lz),
    .DISP_EN  (disp_en),
    .SEG      (seg),
    .DIG      (dig),
    .FRAME    (frame)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_n counts clock edges since reset release; the scan position is derived from it.
  int         m_n;
  int         m_snap [3];
  logic [6:0] seg_tab [16];
  logic [6:0] exp_seg;
  logic [2:0] exp_dig;
  logic       exp_frame;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n       = 0;
    m_snap[0] = 0;
    m_snap[1] = 0;
    m_snap[2] = 0;
    exp_seg   = 7'h7F;
    exp_dig   = 3'b111;
    exp_frame = 1'b0;
  endtask

  // Called just after a posedge, with the inputs that were stable across that edge.
  task automatic model_edge();
    int  cnt, s, p, val;
    bit  blank, on;
    cnt   = m_n;
    m_n   = m_n + 1;
    s     = (cnt / P) % 3;
    p     = cnt % P;
    val   = m_snap[s];
    blank = (s == 2 && blank_lz && m_snap[2] == 0) ||
            (s == 1 && blank_lz && m_snap[2] == 0 && m_snap[1] == 0);
    on    = (p >= D) && disp_en && !blank;
    exp_seg   = on ? ~seg_tab[val] : 7'h7F;
    exp_dig   = on ? ~(3'b001 << s) : 3'b111;
    exp_frame = (m_n % FRAME_LEN) == 0;
    if (exp_frame) begin
      m_snap[0] = int'(bcd_1);
      m_snap[1] = int'(bcd_10);
      m_snap[2] = int'(bcd_100);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    check_val({tag, "_dig"}, 32'(dig), 32'(exp_dig));
    check_val({tag, "_frame"}, 32'(frame), 32'(exp_frame));
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 2) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic mutate_inputs();
    if ($urandom_range(0, 19) == 0) begin
      bcd_1   = rnd_digit();
      bcd_10  = rnd_digit();
      bcd_100 = rnd_digit();
    end
    if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
    if (disp_en) begin
      if ($urandom_range(0, 29) == 0) disp_en = 1'b0;
    end else if ($urandom_range(0, 7) == 0) begin
      disp_en = 1'b1;
    end
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    bcd_1    = 4'd3;
    bcd_10   = 4'd2;
    bcd_100  = 4'd1;
    blank_lz = 1'b0;
    disp_en  = 1'b1;
    RESET    = 1'b1;
    model_reset();
    #11;
    check_outputs("reset");
    #1 RESET = 1'b0;

    // Held 1/2/3, no blanking: first frame shows 000, later frames show 123.
    for (int i = 0; i < 3 * FRAME_LEN; i++) step("held123");

    // Leading-zero blanking with 007, then tens becomes 5.
    blank_lz = 1'b1;
    bcd_100  = 4'd0;
    bcd_10   = 4'd0;
    bcd_1    = 4'd7;
    for (int i = 0; i < 2 * FRAME_LEN; i++) step("lz007");
    bcd_10 = 4'd5;
    for (int i = 0; i < 2 * FRAME_LEN; i++) step("lz057");

    // Dash on ones with blanked upper digits.
    bcd_10 = 4'd0;
    bcd_1  = 4'hB;
    for (int i = 0; i < 2 * FRAME_LEN; i++) step("dash");

    // Randomized run: mid-frame input changes, DISP_EN bursts, BLANK_LZ toggles.
    for (int i = 0; i < 1500; i++) begin
      mutate_inputs();
      step("rand");
    end

    // Async reset in the middle of a hundreds slot.
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (((m_n / P) % 3) == 2 && (m_n % P) == 4) break;
      step("seek");
    end
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    repeat (2) begin
      @(posedge CLK);
      #1;
      check_outputs("rst_held");
    end
    #2 RESET = 1'b0;
    disp_en = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) step("post_rst");
    for (int i = 0; i < 600; i++) begin
      mutate_inputs();
      step("rand2");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the 000-999 BCD counter. Takes the three BCD digits (ones, tens, hundreds) and drives a 3-digit common-anode/cathode multiplexed 7-segment display. Uses a refresh prescaler, a three-slot digit scan state machine, per-frame input snapshot (no tearing), dead-time ghost blanking and leading-zero blanking. All outputs are registered.

Parameters:
- PRESCALE, 1000: CLK cycles per digit slot; legal range PRESCALE >= 2.
- DEAD, 4: blank cycles at the start of each slot; legal range 0 <= DEAD < PRESCALE.
- ACTIVE_LOW_SEG, 1: 1 = SEG lines are active-low.
- ACTIVE_LOW_DIG, 1: 1 = DIG lines are active-low.

Ports:
- CLK  in  1  system clock; all state on posedge.
- RESET  in  1  reset; asynchronous, active-high.
- BCD_1  in  4  ones digit.
- BCD_10  in  4  tens digit.
- BCD_100  in  4  hundreds digit.
- BLANK_LZ  in  1  1 = enable leading-zero blanking.
- DISP_EN  in  1  0 = all digits off; scan keeps running.
- SEG  out  7  segments a..g; SEG[0]=a ... SEG[6]=g.
- DIG  out  3  digit enables; DIG[0]=ones, DIG[1]=tens, DIG[2]=hundreds.
- FRAME  out  1  one-cycle pulse marking the start of a new frame.

Behaviour:
- **Reset values** (RESET=1, asynchronous):
  - prescaler p=0, state=S_ONES, snapshot digits=0.
  - SEG = all segments off (polarity applied).
  - DIG = all digits off (polarity applied).
  - FRAME=0.
- **Prescaler:** p counts 0..PRESCALE-1 and wraps to 0. The slot ends on the cycle where p==PRESCALE-1.
- **Slot state machine:** S_ONES -> S_TENS -> S_HUNDS -> S_ONES. It advances only at slot end. Frame length = 3*PRESCALE cycles.
- **Snapshot:** on the cycle where state==S_HUNDS and p==PRESCALE-1, BCD_1/10/100 are captured into snapshot registers. The same edge enters S_ONES. Input changes mid-frame have no effect until the next capture.
- **FRAME:** registered; high for exactly the one cycle after each capture edge. It does not pulse for the first frame after reset.
- **Decode** (active-high internal code, bit0=a):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Codes 10-15 = 0x40 (dash).
  - SEG = ACTIVE_LOW_SEG ? ~code : code.
- **Digit drive:** for the current slot, the digit's DIG bit is active iff all of the following hold; all other DIG bits are inactive:
  - p >= DEAD;
  - DISP_EN=1;
  - the digit is not blanked.
- **Leading-zero blanking** (BLANK_LZ=1):
  - Hundreds is blanked if its snapshot==0.
  - Tens is blanked if hundreds==0 and tens==0.
  - Ones is never blanked.
  - Codes 10-15 are never treated as zero.
- **SEG when digit inactive:** SEG is driven all-off during dead time, blanking, or DISP_EN=0.
- **Latency:** SEG/DIG/FRAME are registered from the (state, p, snapshot, DISP_EN, BLANK_LZ) of the previous cycle. That is 1 cycle of latency.
- **DISP_EN / BLANK_LZ:** not snapshotted; they act with 1-cycle latency.
- **Reset mid-frame:** everything returns to reset values immediately. After release, the scan restarts at S_ONES with p=0 and snapshot=0. The display shows "0" (BLANK_LZ=1) or "000" (BLANK_LZ=0) until the first capture.
- **DEAD=0:** no dead time; a digit is on for the full slot.

Decomposition:
- **Package seg7_pkg:**
  - state encoding S_ONES/S_TENS/S_HUNDS;
  - 7-bit segment code constants SEG_0..SEG_9 and SEG_DASH;
  - digit index constants.
- **Sub-module seg7_decode:** combinational, 4-bit BCD -> 7-bit active-high code. Instantiated once, fed by a mux of the current slot's snapshot digit.
- The parent holds the prescaler, FSM, snapshot, blanking logic, polarity and output registers.

Test Plan:
All scenarios use PRESCALE=8, DEAD=2, ACTIVE_LOW_SEG=1, ACTIVE_LOW_DIG=1, DISP_EN=1 unless stated.
1. Reset, BCD=1/2/3 held, BLANK_LZ=0.
   - First frame shows 0 on all digits: DIG=3'b110 with SEG=~0x3F.
   - From the second frame: ones slot SEG=~0x4F, tens ~0x5B, hundreds ~0x06.
   - Each digit is on for 6 of 8 cycles; FRAME pulses every 24 cycles.
2. BLANK_LZ=1, BCD_100=0, BCD_10=0, BCD_1=7.
   - Only DIG[0] ever asserts (SEG=~0x07); tens and hundreds slots show DIG=3'b111 and SEG=7'h7F.
   - Then BCD_10=5: tens appears from the next frame.
3. Mid-frame stimulus change: change BCD_1 from 4 to 9 during the tens slot.
   - The ones display stays 0x66 until the next capture, then shows 0x6F.
4. BCD_1=4'hB.
   - Ones slot SEG=~0x40.
   - With BLANK_LZ=1 and hundreds=0, tens=0: tens and hundreds are blanked, ones shows the dash.
5. DISP_EN=0 for 10 cycles mid-slot.
   - DIG=3'b111 from 1 cycle after assertion; p and the FSM continue.
   - On re-enable, the correct slot's digit resumes 1 cycle later.
6. Assert RESET asynchronously mid hundreds slot.
   - DIG=3'b111, SEG=7'h7F, FRAME=0 immediately (no clock edge).
   - After release, ones slot active again at p=DEAD+1 cycles.
